// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    WR_DATA,
    RD_ISSUE,
    RD_WAIT,
    RD_PUSH,
    RD_DRAIN
  } state_e;

  localparam logic [7:0] CMD_WRITE        = 8'h01;
  localparam logic [7:0] CMD_READ         = 8'h02;
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  // States in which the controller consumes RX bytes.
  function automatic logic rx_ready_state(input state_e s);
    return (s == IDLE) || (s == ADDR) || (s == LEN) || (s == WR_DATA) || (s == RD_DRAIN);
  endfunction

endpackage

// File: rtl/spi_cmd_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module spi_cmd_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins, otherwise count down and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses CMD/ADDR/LEN/payload frames from the RX byte
// stream, drives an 8-bit register bus and returns read data on the TX stream.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         RD_TIMEOUT = 64,
  parameter logic [7:0] ERR_BYTE   = ERR_BYTE_DEFAULT
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,
  input  logic [7:0]        s_axis_rx_tdata,
  input  logic              s_axis_rx_tvalid,
  output logic              s_axis_rx_tready,
  output logic [7:0]        m_axis_tx_tdata,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  input  logic              frame_abort,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rvalid,
  output logic              busy,
  output logic              bad_cmd
);

  localparam int TIMER_W = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              is_read_q, is_read_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        count_q, count_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic              rx_ready_q, rx_ready_d;
  logic              rx_fire;
  logic              timer_load, timer_en, timer_done;

  assign rx_fire = s_axis_rx_tvalid && rx_ready_q;

  spi_cmd_timer #(.W(TIMER_W)) u_timer (
    .clk      (axis_aclk),
    .rst      (axis_areset),
    .load     (timer_load),
    .load_val (TIMER_W'(RD_TIMEOUT - 1)),
    .en       (timer_en),
    .done     (timer_done)
  );

  // Frame parser and bus sequencer: next-state and next-output computation.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    count_d     = count_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    bad_cmd_d   = 1'b0;
    timer_load  = 1'b0;
    timer_en    = 1'b0;

    if (frame_abort) begin
      // Abort beats any RX byte arriving in the same cycle.
      state_d    = IDLE;
      tx_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (rx_fire) begin
          if ((s_axis_rx_tdata == CMD_WRITE) || (s_axis_rx_tdata == CMD_READ)) begin
            is_read_d = (s_axis_rx_tdata == CMD_READ);
            state_d   = ADDR;
          end else begin
            bad_cmd_d = 1'b1;
          end
        end
        ADDR: if (rx_fire) begin
          addr_d  = s_axis_rx_tdata;
          state_d = LEN;
        end
        LEN: if (rx_fire) begin
          count_d = s_axis_rx_tdata;
          if (s_axis_rx_tdata == 8'd0) state_d = IDLE;
          else if (is_read_q)          state_d = RD_ISSUE;
          else                         state_d = WR_DATA;
        end
        WR_DATA: if (rx_fire) begin
          reg_addr_d  = ADDR_W'(addr_q);
          reg_wdata_d = s_axis_rx_tdata;
          reg_we_d    = 1'b1;
          addr_d      = addr_q + 8'd1;
          count_d     = count_q - 8'd1;
          if (count_q == 8'd1) state_d = IDLE;
        end
        RD_ISSUE: begin
          reg_addr_d = ADDR_W'(addr_q);
          reg_re_d   = 1'b1;
          timer_load = 1'b1;
          state_d    = RD_WAIT;
        end
        RD_WAIT: begin
          timer_en = 1'b1;
          // Read data wins over a timeout expiring in the same cycle.
          if (reg_rvalid) begin
            tx_data_d  = reg_rdata;
            tx_valid_d = 1'b1;
            state_d    = RD_PUSH;
          end else if (timer_done) begin
            tx_data_d  = ERR_BYTE;
            tx_valid_d = 1'b1;
            state_d    = RD_PUSH;
          end
        end
        RD_PUSH: if (m_axis_tx_tready) begin
          tx_valid_d = 1'b0;
          state_d    = RD_DRAIN;
        end
        RD_DRAIN: if (rx_fire) begin
          // The dummy byte proves the TX byte has been shifted out.
          addr_d  = addr_q + 8'd1;
          count_d = count_q - 8'd1;
          state_d = (count_q == 8'd1) ? IDLE : RD_ISSUE;
        end
        default: state_d = IDLE;
      endcase
    end

    rx_ready_d = rx_ready_state(state_d);
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q     <= IDLE;
      is_read_q   <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      bad_cmd_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      bad_cmd_q   <= bad_cmd_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  assign s_axis_rx_tready = rx_ready_q;
  assign m_axis_tx_tdata  = tx_data_q;
  assign m_axis_tx_tvalid = tx_valid_q;
  assign reg_addr         = reg_addr_q;
  assign reg_wdata        = reg_wdata_q;
  assign reg_we           = reg_we_q;
  assign reg_re           = reg_re_q;
  assign bad_cmd          = bad_cmd_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus pushes expected bus and TX
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_spi_cmd_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              axis_areset;
  logic [7:0]        s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [7:0]        tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic              frame_abort;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              reg_rvalid;
  logic              busy;
  logic              bad_cmd;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .RD_TIMEOUT(64), .ERR_BYTE(8'hEE)) dut (
    .axis_aclk        (clk),
    .axis_areset      (axis_areset),
    .s_axis_rx_tdata  (s_tdata),
    .s_axis_rx_tvalid (s_tvalid),
    .s_axis_rx_tready (s_tready),
    .m_axis_tx_tdata  (tx_tdata),
    .m_axis_tx_tvalid (tx_tvalid),
    .m_axis_tx_tready (tx_tready),
    .frame_abort      (frame_abort),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_we           (reg_we),
    .reg_re           (reg_re),
    .reg_rdata        (reg_rdata),
    .reg_rvalid       (reg_rvalid),
    .busy             (busy),
    .bad_cmd          (bad_cmd)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and reference memory.
  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];
  int         exp_bad = 0;

  logic [7:0] mem [256];        // what the DUT actually wrote
  logic [7:0] model_mem [256];  // what the frames say should be there
  logic       mute = 1'b0;      // memory ignores reads
  logic       tx_hold = 1'b0;   // TX sink refuses bytes
  logic       late_pulse = 1'b0;
  logic       abort_seen, rst_seen;

  always @(posedge clk) begin
    abort_seen <= frame_abort;
    rst_seen   <= axis_areset;
  end

  // Monitor: compare every DUT event against the head of its queue.
  logic       tx_pend = 1'b0;
  logic [7:0] tx_prev = '0;
  always @(negedge clk) begin
    wr_t w;
    if (reg_we || reg_re) check("we_re_exclusive", {31'b0, reg_we & reg_re}, 0);
    if (reg_we === 1'b1) begin
      mem[reg_addr[7:0]] = reg_wdata;
      check("write_expected", {31'b0, exp_wr.size() > 0}, 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", reg_addr, w.a);
        check("wr_data", reg_wdata, w.d);
      end
    end
    if (reg_re === 1'b1) begin
      check("read_expected", {31'b0, exp_rd.size() > 0}, 1);
      if (exp_rd.size() > 0) check("rd_addr", reg_addr, exp_rd.pop_front());
    end
    if (tx_tvalid === 1'b1 && tx_tready) begin
      check("tx_expected", {31'b0, exp_tx.size() > 0}, 1);
      if (exp_tx.size() > 0) check("tx_data", tx_tdata, exp_tx.pop_front());
    end
    if (bad_cmd === 1'b1) begin
      check("bad_cmd_expected", {31'b0, exp_bad > 0}, 1);
      if (exp_bad > 0) exp_bad--;
    end
    if (tx_pend && !abort_seen && !rst_seen) begin
      check("tx_valid_held", {31'b0, tx_tvalid}, 1);
      check("tx_data_held", tx_tdata, tx_prev);
    end
    tx_pend = (tx_tvalid === 1'b1) && !tx_tready;
    tx_prev = tx_tdata;
  end

  // Register memory: answers each read 1..4 cycles later unless muted.
  initial begin
    logic [7:0] a;
    int lat;
    reg_rvalid = 1'b0;
    reg_rdata  = '0;
    forever begin
      @(negedge clk);
      reg_rvalid = 1'b0;
      reg_rdata  = 8'($urandom);
      if (late_pulse) begin
        reg_rvalid = 1'b1;
        reg_rdata  = 8'h55;
        late_pulse = 1'b0;
      end
      if (reg_re === 1'b1 && !mute) begin
        a   = reg_addr[7:0];
        lat = $urandom_range(1, 4);
        repeat (lat) begin
          @(negedge clk);
          reg_rvalid = 1'b0;
          reg_rdata  = 8'($urandom);
        end
        reg_rdata  = mem[a];
        reg_rvalid = 1'b1;
      end
    end
  end

  // TX sink with random backpressure.
  initial begin
    tx_tready = 1'b0;
    forever begin
      @(negedge clk);
      tx_tready = tx_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rx_handshake_bound", {31'b0, n < 500}, 1);
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      logic [7:0] aa;
      aa = a + 8'(i);
      exp_wr.push_back('{a: aa, d: d[i]});
      model_mem[aa] = d[i];
    end
    send_byte(8'h01);
    send_byte(a);
    send_byte(8'(d.size()));
    for (int i = 0; i < d.size(); i++) send_byte(d[i]);
  endtask

  task automatic rd_frame(input logic [7:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] aa;
      aa = a + 8'(i);
      exp_rd.push_back(aa);
      exp_tx.push_back(model_mem[aa]);
    end
    send_byte(8'h02);
    send_byte(a);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(8'($urandom));
  endtask

  initial begin
    logic [7:0] pl[$];
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    axis_areset = 1'b1;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    frame_abort = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_we", {31'b0, reg_we}, 0);
    check("rst_re", {31'b0, reg_re}, 0);
    check("rst_tvalid", {31'b0, tx_tvalid}, 0);
    check("rst_tdata", tx_tdata, 0);
    check("rst_bad_cmd", {31'b0, bad_cmd}, 0);
    check("rst_rx_tready", {31'b0, s_tready}, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    axis_areset = 1'b0;

    // Write burst.
    pl = {8'hAA, 8'hBB, 8'hCC};
    wr_frame(8'h10, pl);
    check("busy_after_write", {31'b0, busy}, 0);

    // Read burst.
    rd_frame(8'h20, 2);
    check("busy_after_read", {31'b0, busy}, 0);

    // Address wrap.
    pl = {8'h11, 8'h22};
    wr_frame(8'hFF, pl);
    rd_frame(8'hFF, 2);

    // Read timeout, late response ignored, next read normal.
    mute    = 1'b1;
    tx_hold = 1'b1;
    exp_rd.push_back(8'h50);
    exp_tx.push_back(8'hEE);
    send_byte(8'h02);
    send_byte(8'h50);
    send_byte(8'h01);
    n = 0;
    @(negedge clk);
    while (reg_re !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_re_bound", {31'b0, n < 100}, 1);
    n = 0;
    while (tx_tvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 64);
    late_pulse = 1'b1;
    repeat (4) @(negedge clk);
    check("timeout_byte_after_late", tx_tdata, 8'hEE);
    mute    = 1'b0;
    tx_hold = 1'b0;
    send_byte(8'h00);
    rd_frame(8'h51, 1);

    // Bad command and zero length.
    exp_bad++;
    send_byte(8'h7F);
    check("busy_after_bad", {31'b0, busy}, 0);
    send_byte(8'h01);
    check("busy_mid_frame", {31'b0, busy}, 1);
    send_byte(8'h30);
    send_byte(8'h00);
    check("busy_after_zero_len", {31'b0, busy}, 0);

    // Abort during RD_PUSH with tready held low.
    tx_hold = 1'b1;
    exp_rd.push_back(8'h60);
    send_byte(8'h02);
    send_byte(8'h60);
    send_byte(8'h02);
    n = 0;
    while (tx_tvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_push_bound", {31'b0, n < 200}, 1);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    check("abort_tvalid", {31'b0, tx_tvalid}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    repeat (20) @(negedge clk);
    tx_hold = 1'b0;

    // Reset in the middle of a write burst.
    exp_wr.push_back('{a: 8'h70, d: 8'h01});
    exp_wr.push_back('{a: 8'h71, d: 8'h02});
    model_mem[8'h70] = 8'h01;
    model_mem[8'h71] = 8'h02;
    send_byte(8'h01);
    send_byte(8'h70);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    axis_areset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_we", {31'b0, reg_we}, 0);
    check("midrst_reg_addr", reg_addr, 0);
    check("midrst_reg_wdata", reg_wdata, 0);
    check("midrst_rx_tready", {31'b0, s_tready}, 0);
    axis_areset = 1'b0;
    pl = {8'h5A};
    wr_frame(8'h40, pl);
    rd_frame(8'h70, 2);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int r;
      logic [7:0] a, c;
      r = $urandom_range(0, 9);
      a = 8'($urandom);
      if (r < 4) begin
        pl = {};
        for (int i = 0; i < $urandom_range(1, 4); i++) pl.push_back(8'($urandom));
        wr_frame(a, pl);
      end else if (r < 8) begin
        rd_frame(a, $urandom_range(1, 3));
      end else if (r == 8) begin
        c = 8'($urandom_range(3, 255));
        exp_bad++;
        send_byte(c);
      end else begin
        send_byte(8'h02);
        send_byte(a);
        send_byte(8'h00);
      end
    end

    // Drain and confirm every expected event occurred.
    n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 || exp_bad != 0 || busy)
           && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("left_writes", exp_wr.size(), 0);
    check("left_reads", exp_rd.size(), 0);
    check("left_tx", exp_tx.size(), 0);
    check("left_bad", exp_bad, 0);
    check("final_busy", {31'b0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI-slave AXIS byte streams and an 8-bit internal register bus.
- Parses framed SPI commands (cmd, addr, len, data) from the RX byte stream and issues register writes or reads.
- Returns read data on the TX byte stream, one byte per SPI byte clocked by the master.
- Is the only master of the SPI slave's TX stream and the only consumer of its RX stream.

Parameters:
- ADDR_W, 8, register address width; the address byte is zero-extended to this width.
- RD_TIMEOUT, 64, cycles to wait for reg_rvalid before substituting the error byte.
- ERR_BYTE, 8'hEE, byte returned on read timeout.

Ports:
- axis_aclk  in  1  system clock
- axis_areset  in  1  synchronous active-high reset
- s_axis_rx_tdata  in  8  byte received from SPI MOSI
- s_axis_rx_tvalid  in  1  RX byte valid
- s_axis_rx_tready  out  1  controller accepts RX byte
- m_axis_tx_tdata  out  8  byte for SPI MISO
- m_axis_tx_tvalid  out  1  TX byte valid
- m_axis_tx_tready  in  1  SPI slave accepts TX byte
- frame_abort  in  1  one-cycle pulse on chip-select deassert, already synchronised to axis_aclk
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid with reg_rvalid
- reg_rvalid  in  1  read data valid; arrives 1 or more cycles after reg_re
- busy  out  1  high in any state other than IDLE
- bad_cmd  out  1  one-cycle pulse when an unknown command byte is received

Behaviour:
- Reset: state IDLE; all outputs 0; internal addr, count and timer 0. Reset overrides every event, including mid-frame.
- Frame format: CMD, ADDR, LEN, then LEN payload bytes.
  - CMD 8'h01 = write; CMD 8'h02 = read.
  - LEN 0 ends the frame with no bus access.
- Address sequencing: addr increments after each access and wraps modulo 2^8 (8'hFF to 8'h00) before zero-extension.
- s_axis_rx_tready: high in IDLE, ADDR, LEN, WR_DATA and RD_DRAIN; low in all other states.
- States and transitions:
  - IDLE: on an RX beat with CMD = 01 or 02, latch the command and go to ADDR. On any other CMD, pulse bad_cmd for one cycle and stay in IDLE.
  - ADDR: on an RX beat, latch addr and go to LEN.
  - LEN: on an RX beat, latch count. If the value is 0, go to IDLE. Otherwise go to WR_DATA (write command) or RD_ISSUE (read command).
  - WR_DATA: on an RX beat, drive reg_wdata and reg_addr, pulse reg_we on the next cycle, then increment addr and decrement count. When count reaches 0 go to IDLE, otherwise stay in WR_DATA. Write latency is RX handshake +1 cycle.
  - RD_ISSUE: pulse reg_re for one cycle with reg_addr = addr, clear the timer, go to RD_WAIT.
  - RD_WAIT: on reg_rvalid, register reg_rdata and go to RD_PUSH. If the timer reaches RD_TIMEOUT-1, register ERR_BYTE instead and go to RD_PUSH. A reg_rvalid that arrives after the timeout is ignored.
  - RD_PUSH: hold m_axis_tx_tvalid=1 with tdata stable until tready, then go to RD_DRAIN. tvalid never drops before the handshake.
  - RD_DRAIN: accept and discard one dummy RX byte, which confirms the TX byte was shifted out. Then increment addr and decrement count; go to RD_ISSUE if count is nonzero, otherwise IDLE.
- frame_abort: in any state, go to IDLE on the next cycle and drop m_axis_tx_tvalid. A reg_we or reg_re pulse already registered on that same cycle still completes; no further strobes are issued. A frame_abort received in IDLE is a no-op.
- Simultaneous frame_abort and RX beat: abort wins and the RX byte is dropped. Simultaneous reg_rvalid and timeout: reg_rdata wins.
- reg_we and reg_re are never high in the same cycle, and never high in consecutive cycles for reads (each read waits for its response).
- busy = (state != IDLE).

Decomposition:
- Package spi_cmd_pkg:
  - state enum: IDLE, ADDR, LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_PUSH, RD_DRAIN;
  - constants CMD_WRITE=8'h01, CMD_READ=8'h02, default ERR_BYTE.
- One sub-module, spi_cmd_timer: loadable down-counter with a done flag, used for the RD_WAIT timeout. Everything else stays flat.

Test Plan:
- Write burst: RX 01,10,03,AA,BB,CC -> reg_we pulses at addrs 10,11,12 with data AA,BB,CC; busy falls after the third write; no TX beats.
- Read burst, 2-cycle memory: RX 02,20,02, then 2 dummy bytes -> reg_re at 20 then 21; TX beats carry mem[20] then mem[21]; second reg_re only after the first dummy byte is accepted.
- Address wrap: write 01,FF,02,11,22 -> writes at FF and 00 (ADDR_W=8; with ADDR_W=10, 0x000 not 0x100).
- Timeout: read with reg_rvalid never asserted -> TX byte EE after 64 cycles; a late reg_rvalid is ignored; the next read proceeds normally.
- Bad command and zero length: RX 7F -> bad_cmd one pulse, stays IDLE. RX 01,30,00 -> no strobes, back to IDLE.
- Abort and reset: frame_abort during RD_PUSH with tready=0 -> tvalid drops next cycle, IDLE, no further reg_re. axis_areset asserted mid write burst -> all outputs 0 next cycle and the next frame parses from CMD.
